// File: rtl/irq_arbiter_pkg.sv
// rtl/irq_arbiter_pkg.sv - shared constants, state type and grant helper for irq_arbiter
//
// Purpose: FSM state encoding (one-hot), default MSI vectors and holdoff,
//          and the round-robin pick used when granting a source.
package irq_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_ASSERT  = 3'b010,
        ST_HOLDOFF = 3'b100
    } irq_state_t;

    localparam logic [7:0]  DEF_RX_VECTOR      = 8'h00;
    localparam logic [7:0]  DEF_TX_VECTOR      = 8'h01;
    localparam logic [15:0] DEF_HOLDOFF_CYCLES = 16'd1024;

    // Returns 1 when Rx should be granted. With both requests pending the
    // source that did not win last time gets the grant.
    function automatic logic pick_rx(input logic rx_req, input logic tx_req,
                                     input logic last_rx);
        return rx_req && (!tx_req || !last_rx);
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - request/ack and PCIe cfg_interrupt bundle for irq_arbiter
//
// Purpose: groups the host enable, the two level requests, their acks, the
//          PCIe interrupt handshake and the accepted-interrupt counter.
// Modports:
//   slave  - the arbiter: consumes enable/requests/rdy, drives interrupt/acks/count
//   master - the environment: drives enable/requests/rdy, observes the rest
interface irq_arbiter_if;

    logic        irq_en;
    logic        rx_send_irq;
    logic        tx_send_irq;
    logic        cfg_interrupt_rdy;
    logic        cfg_interrupt;
    logic [7:0]  cfg_interrupt_di;
    logic        rx_irq_ack;
    logic        tx_irq_ack;
    logic [31:0] irq_cnt;

    modport slave (
        input  irq_en, rx_send_irq, tx_send_irq, cfg_interrupt_rdy,
        output cfg_interrupt, cfg_interrupt_di, rx_irq_ack, tx_irq_ack, irq_cnt
    );

    modport master (
        output irq_en, rx_send_irq, tx_send_irq, cfg_interrupt_rdy,
        input  cfg_interrupt, cfg_interrupt_di, rx_irq_ack, tx_irq_ack, irq_cnt
    );

endinterface

// File: rtl/irq_holdoff_timer.sv
// rtl/irq_holdoff_timer.sv - 16-bit load/decrement counter with zero flag
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (count clears to 0)
//   load        - load load_value (takes precedence over dec)
//   load_value  - value to load
//   dec         - decrement by one; saturates at 0
//   zero        - count is 0
module irq_holdoff_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - round-robin Rx/Tx MSI arbiter with PCIe handshake and holdoff
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - irq_arbiter_if.slave: irq_en, rx/tx_send_irq, cfg_interrupt_rdy in;
//          cfg_interrupt, cfg_interrupt_di, rx/tx_irq_ack, irq_cnt out
// Parameters:
//   HOLDOFF_CYCLES - idle cycles enforced after each accepted interrupt (1..65535)
//   RX_VECTOR, TX_VECTOR - MSI vectors presented on cfg_interrupt_di
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter logic [15:0] HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter logic [7:0]  RX_VECTOR      = DEF_RX_VECTOR,
    parameter logic [7:0]  TX_VECTOR      = DEF_TX_VECTOR
) (
    input  logic           clk,
    input  logic           rst,
    irq_arbiter_if.slave   bus
);

    // Loading N-1 and leaving on the cycle after zero is read gives exactly
    // N cycles in HOLDOFF.
    localparam logic [15:0] HOLDOFF_LOAD = HOLDOFF_CYCLES - 16'd1;

    irq_state_t  state;
    logic        last_rx;       // 1: Rx holds (or last held) the grant
    logic        int_q;
    logic [7:0]  di_q;
    logic        rx_ack_q;
    logic        tx_ack_q;
    logic [31:0] irq_cnt_q;

    logic        grant_rx;
    logic        accept;
    logic        timer_zero;

    assign grant_rx = pick_rx(bus.rx_send_irq, bus.tx_send_irq, last_rx);
    assign accept   = (state == ST_ASSERT) && bus.cfg_interrupt_rdy;

    irq_holdoff_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (HOLDOFF_LOAD),
        .dec        (state == ST_HOLDOFF),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_rx   <= 1'b0;
            int_q     <= 1'b0;
            di_q      <= 8'h00;
            rx_ack_q  <= 1'b0;
            tx_ack_q  <= 1'b0;
            irq_cnt_q <= 32'd0;
        end else begin
            rx_ack_q <= 1'b0;
            tx_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.irq_en && (bus.rx_send_irq || bus.tx_send_irq)) begin
                        last_rx <= grant_rx;
                        di_q    <= grant_rx ? RX_VECTOR : TX_VECTOR;
                        int_q   <= 1'b1;
                        state   <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    // Requests and irq_en are deliberately ignored until the
                    // core accepts, so a dropped enable cannot strand it.
                    if (accept) begin
                        int_q     <= 1'b0;
                        rx_ack_q  <= last_rx;
                        tx_ack_q  <= !last_rx;
                        irq_cnt_q <= irq_cnt_q + 32'd1;
                        state     <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_zero) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    int_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_interrupt    = int_q;
    assign bus.cfg_interrupt_di = di_q;
    assign bus.rx_irq_ack       = rx_ack_q;
    assign bus.tx_irq_ack       = tx_ack_q;
    assign bus.irq_cnt          = irq_cnt_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - self-checking bench for irq_arbiter (holdoff 4 and 10 instances)
module tb_irq_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic irq_en;
    logic rx;
    logic tx;
    logic rdy;

    irq_arbiter_if bus_a ();
    irq_arbiter_if bus_b ();

    assign bus_a.irq_en            = irq_en;
    assign bus_a.rx_send_irq       = rx;
    assign bus_a.tx_send_irq       = tx;
    assign bus_a.cfg_interrupt_rdy = rdy;
    assign bus_b.irq_en            = irq_en;
    assign bus_b.rx_send_irq       = rx;
    assign bus_b.tx_send_irq       = tx;
    assign bus_b.cfg_interrupt_rdy = rdy;

    irq_arbiter #(.HOLDOFF_CYCLES(16'd4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    irq_arbiter #(.HOLDOFF_CYCLES(16'd10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: each instance is either presenting an interrupt or
    // not, and may only start a new one once the cycle count reaches the
    // point its holdoff window ends.
    int          hold [2] = '{4, 10};
    bit          m_busy [2];
    bit          m_last_rx [2];
    longint      m_ready_at [2];
    logic        m_int [2];
    logic [7:0]  m_di [2];
    logic        m_rxa [2];
    logic        m_txa [2];
    logic [31:0] m_cnt [2];
    longint      cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]     = 1'b0;
            m_last_rx[i]  = 1'b0;
            m_ready_at[i] = 0;
            m_int[i]      = 1'b0;
            m_di[i]       = 8'h00;
            m_rxa[i]      = 1'b0;
            m_txa[i]      = 1'b0;
            m_cnt[i]      = 32'd0;
        end
    endtask

    task automatic model_step(input int i);
        bit g;
        if (rst) begin
            m_busy[i] = 1'b0; m_last_rx[i] = 1'b0; m_ready_at[i] = 0;
            m_int[i] = 1'b0; m_di[i] = 8'h00; m_rxa[i] = 1'b0; m_txa[i] = 1'b0;
            m_cnt[i] = 32'd0;
            return;
        end
        m_rxa[i] = 1'b0;
        m_txa[i] = 1'b0;
        if (m_busy[i]) begin
            if (rdy) begin
                m_busy[i]     = 1'b0;
                m_int[i]      = 1'b0;
                m_rxa[i]      = m_last_rx[i];
                m_txa[i]      = !m_last_rx[i];
                m_cnt[i]      = m_cnt[i] + 32'd1;
                m_ready_at[i] = cyc + hold[i] + 1;
            end
        end else if (cyc >= m_ready_at[i] && irq_en && (rx || tx)) begin
            g = (rx && tx) ? !m_last_rx[i] : rx;
            m_last_rx[i] = g;
            m_busy[i]    = 1'b1;
            m_int[i]     = 1'b1;
            m_di[i]      = g ? 8'h00 : 8'h01;
        end
    endtask

    task automatic compare_all();
        check("a.cfg_interrupt",    bus_a.cfg_interrupt,    m_int[0]);
        check("a.cfg_interrupt_di", bus_a.cfg_interrupt_di, m_di[0]);
        check("a.rx_irq_ack",       bus_a.rx_irq_ack,       m_rxa[0]);
        check("a.tx_irq_ack",       bus_a.tx_irq_ack,       m_txa[0]);
        check("a.irq_cnt",          bus_a.irq_cnt,          m_cnt[0]);
        check("b.cfg_interrupt",    bus_b.cfg_interrupt,    m_int[1]);
        check("b.cfg_interrupt_di", bus_b.cfg_interrupt_di, m_di[1]);
        check("b.rx_irq_ack",       bus_b.rx_irq_ack,       m_rxa[1]);
        check("b.tx_irq_ack",       bus_b.tx_irq_ack,       m_txa[1]);
        check("b.irq_cnt",          bus_b.irq_cnt,          m_cnt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en, rq_rx, rq_tx, rd;
        logic        cint;
        logic [7:0]  di;
        logic        rxa, txa;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic r, input logic t, input logic d,
                                input logic ci, input logic [7:0] di, input logic ra,
                                input logic ta, input logic [31:0] c);
        vec_t v;
        v.en = en; v.rq_rx = r; v.rq_tx = t; v.rd = d;
        v.cint = ci; v.di = di; v.rxa = ra; v.txa = ta; v.cnt = c;
        return v;
    endfunction

    vec_t tbl [17];

    // Contention / holdoff observation state
    logic [7:0] di_seq_a [$];
    logic [7:0] di_seq_b [$];
    int         gaps_a [$];
    int         gaps_b [$];
    int         low_a, low_b;
    bit         seen_a, seen_b;
    bit         prev_a, prev_b;
    int         hi_cnt;
    bit         got;

    initial begin
        rst = 1'b1; irq_en = 1'b0; rx = 1'b0; tx = 1'b0; rdy = 1'b0;
        model_reset();
        #1;
        check("reset_async.a.cfg_interrupt", bus_a.cfg_interrupt, 1'b0);
        check("reset_async.a.irq_cnt", bus_a.irq_cnt, 32'd0);
        tick();
        tick();
        check("reset.a.cfg_interrupt_di", bus_a.cfg_interrupt_di, 8'h00);
        rst = 1'b0;

        // Rows: inputs held for one cycle, expected outputs after the edge
        // closing that cycle (instance with holdoff 4).
        tbl[0]  = mk(1,1,0,0, 1,8'h00,0,0, 0);
        tbl[1]  = mk(0,0,1,0, 1,8'h00,0,0, 0);
        tbl[2]  = mk(0,0,0,0, 1,8'h00,0,0, 0);
        tbl[3]  = mk(1,0,0,1, 0,8'h00,1,0, 1);
        tbl[4]  = mk(1,1,1,1, 0,8'h00,0,0, 1);
        tbl[5]  = mk(1,1,1,1, 0,8'h00,0,0, 1);
        tbl[6]  = mk(1,1,1,1, 0,8'h00,0,0, 1);
        tbl[7]  = mk(1,1,1,1, 0,8'h00,0,0, 1);
        tbl[8]  = mk(1,1,1,1, 1,8'h01,0,0, 1);
        tbl[9]  = mk(0,0,0,1, 0,8'h01,0,1, 2);
        tbl[10] = mk(1,1,1,0, 0,8'h01,0,0, 2);
        tbl[11] = mk(1,1,1,0, 0,8'h01,0,0, 2);
        tbl[12] = mk(1,1,1,0, 0,8'h01,0,0, 2);
        tbl[13] = mk(1,1,1,0, 0,8'h01,0,0, 2);
        tbl[14] = mk(1,1,1,0, 1,8'h00,0,0, 2);
        tbl[15] = mk(0,0,0,0, 1,8'h00,0,0, 2);
        tbl[16] = mk(0,0,0,1, 0,8'h00,1,0, 3);

        for (int k = 0; k < 17; k++) begin
            irq_en = tbl[k].en; rx = tbl[k].rq_rx; tx = tbl[k].rq_tx; rdy = tbl[k].rd;
            tick();
            check($sformatf("tbl%0d.cfg_interrupt", k), bus_a.cfg_interrupt, tbl[k].cint);
            check($sformatf("tbl%0d.di", k), bus_a.cfg_interrupt_di, tbl[k].di);
            check($sformatf("tbl%0d.rx_ack", k), bus_a.rx_irq_ack, tbl[k].rxa);
            check($sformatf("tbl%0d.tx_ack", k), bus_a.tx_irq_ack, tbl[k].txa);
            check($sformatf("tbl%0d.irq_cnt", k), bus_a.irq_cnt, tbl[k].cnt);
        end

        irq_en = 1'b0; rx = 1'b0; tx = 1'b0; rdy = 1'b0;
        repeat (20) tick();

        // Enable low: nothing may be issued
        irq_en = 1'b0; rx = 1'b1; tx = 1'b1;
        hi_cnt = 0;
        repeat (50) begin
            tick();
            if (bus_a.cfg_interrupt || bus_b.cfg_interrupt) hi_cnt++;
        end
        check("irq_en_low.cycles_high", hi_cnt, 0);

        // Contention with rdy tied high, starting from reset
        rx = 1'b0; tx = 1'b0;
        do_reset();
        irq_en = 1'b1; rx = 1'b1; tx = 1'b1; rdy = 1'b1;
        low_a = 0; low_b = 0; seen_a = 0; seen_b = 0; prev_a = 0; prev_b = 0;
        repeat (60) begin
            tick();
            if (bus_a.cfg_interrupt && !prev_a) begin
                di_seq_a.push_back(bus_a.cfg_interrupt_di);
                if (seen_a) gaps_a.push_back(low_a);
                seen_a = 1; low_a = 0;
            end else if (!bus_a.cfg_interrupt) low_a++;
            if (bus_b.cfg_interrupt && !prev_b) begin
                di_seq_b.push_back(bus_b.cfg_interrupt_di);
                if (seen_b) gaps_b.push_back(low_b);
                seen_b = 1; low_b = 0;
            end else if (!bus_b.cfg_interrupt) low_b++;
            prev_a = bus_a.cfg_interrupt;
            prev_b = bus_b.cfg_interrupt;
        end
        check("contention.a.grants", (di_seq_a.size() >= 3), 1);
        check("contention.b.grants", (di_seq_b.size() >= 3), 1);
        if (di_seq_a.size() >= 3 && gaps_a.size() >= 2) begin
            check("contention.a.grant0", di_seq_a[0], 8'h00);
            check("contention.a.grant1", di_seq_a[1], 8'h01);
            check("contention.a.grant2", di_seq_a[2], 8'h00);
            check("contention.a.gap0", gaps_a[0], 5);
            check("contention.a.gap1", gaps_a[1], 5);
        end
        if (di_seq_b.size() >= 3 && gaps_b.size() >= 2) begin
            check("holdoff.b.grant1", di_seq_b[1], 8'h01);
            check("holdoff.b.gap0", gaps_b[0], 11);
            check("holdoff.b.gap1", gaps_b[1], 11);
        end

        // Reset while cfg_interrupt is high
        rdy = 1'b0; rx = 1'b1; tx = 1'b0; irq_en = 1'b1;
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick();
            if (bus_a.cfg_interrupt) got = 1;
        end
        check("midreset.reached_assert", got, 1);
        rdy = 1'b1;
        rst = 1'b1;
        model_reset();
        #1;
        check("midreset.a.cfg_interrupt", bus_a.cfg_interrupt, 1'b0);
        tick();
        check("midreset.a.rx_ack", bus_a.rx_irq_ack, 1'b0);
        check("midreset.a.irq_cnt", bus_a.irq_cnt, 32'd0);
        rst = 1'b0; rx = 1'b0; rdy = 1'b0;
        repeat (2) tick();

        // Counter wrap
        force dut_a.irq_cnt_q = 32'hFFFF_FFFF;
        m_cnt[0] = 32'hFFFF_FFFF;
        #1;
        release dut_a.irq_cnt_q;
        rx = 1'b1; irq_en = 1'b1; rdy = 1'b0;
        tick();
        rdy = 1'b1; rx = 1'b0;
        tick();
        check("wrap.a.irq_cnt", bus_a.irq_cnt, 32'd0);
        check("wrap.a.rx_ack", bus_a.rx_irq_ack, 1'b1);
        rdy = 1'b0;
        repeat (12) tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            irq_en = ($urandom_range(0, 7) != 0);
            rx     = $urandom_range(0, 1);
            tx     = $urandom_range(0, 1);
            rdy    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
